aes_core_dispatch: RTL
======================

AES_CORE_DISPATCH -- requirements
Module: aes_core_dispatch

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of AES cores served (power of two, 2..8).
REQ-002 SHALL have port CLK_I  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port RESET_I  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port CE_I  input  1  clock enable; low freezes all state.
REQ-005 SHALL have port IN_DATA_I  input  8  upstream block byte, LSB byte first.
REQ-006 SHALL have port IN_VALID_I  input  1  upstream byte valid.
REQ-007 SHALL have port IN_READY_O  output  1  dispatcher can accept a new 16-byte block.
REQ-008 SHALL have port OUT_DATA_O  output  8  result byte, in input block order.
REQ-009 SHALL have port OUT_VALID_O  output  1  high for 16 consecutive cycles per result block.
REQ-010 SHALL have port CORE_DATA_O  output  8*NUM_CORES  per-core input byte, core k at [8k+7:8k].
REQ-011 SHALL have port CORE_VALID_O  output  NUM_CORES  per-core input valid.
REQ-012 SHALL have port CORE_READY_I  input  NUM_CORES  per-core ready.
REQ-013 SHALL have port CORE_DATA_I  input  8*NUM_CORES  per-core result byte.
REQ-014 SHALL have port CORE_VALID_I  input  NUM_CORES  per-core result valid, 16-cycle burst, no backpressure.
REQ-015 SHALL have port ERR_O  output  1  sticky protocol-error flag.

Function
REQ-016 SHALL assign blocks to cores strictly round-robin via wr_ptr (0..NUM_CORES-1, wraps to 0).
REQ-017 SHALL keep busy[k] per core: set on first byte dispatched to k, cleared when k's result finishes on OUT.
REQ-018 SHALL drive IN_READY_O = CORE_READY_I[wr_ptr] & ~busy[wr_ptr] & input FSM in IDLE.
REQ-019 Input FSM SHALL have states IDLE, FEED; IDLE->FEED on IN_VALID_I & IN_READY_O (byte 1 taken); FEED->IDLE after byte 16, wr_ptr++.
REQ-020 Byte counter SHALL advance only on IN_VALID_I high; gaps in FEED are forwarded as CORE_VALID_O low.
REQ-021 SHALL register forwarding: CORE_DATA_O/CORE_VALID_O[wr_ptr] follow IN_DATA_I/IN_VALID_I with exactly 1-cycle latency; other cores' valid stay 0.
REQ-022 SHALL capture each core's result burst into a per-core 16-byte buffer, byte i of burst into buffer byte i, setting full[k] after byte 16.
REQ-023 CORE_VALID_I[k] with busy[k]=0 or full[k]=1 SHALL be ignored and SHALL set ERR_O.
REQ-024 Output FSM SHALL have states IDLE, SEND; IDLE->SEND when full[rd_ptr]; SEND emits 16 bytes on consecutive cycles; ->IDLE after byte 16, clears full/busy[rd_ptr], rd_ptr++ (wraps).
REQ-025 First OUT byte SHALL appear the cycle after full[rd_ptr] sets (earliest 1 cycle after last captured byte).
REQ-026 Results completing out of order SHALL wait in their buffer; OUT order SHALL equal input order.
REQ-027 At most one block in flight per core; buffers SHALL never overflow.
REQ-028 Dispatch to core k and release of busy[k] in the same cycle: release wins first; IN_READY_O reflects it next cycle.
REQ-029 CE_I low SHALL hold FSMs, counters, pointers, buffers and all outputs at current values.

Reset
REQ-030 Reset SHALL asynchronously clear wr_ptr, rd_ptr, busy, full, counters, ERR_O; FSMs to IDLE.
REQ-031 During reset IN_READY_O, OUT_VALID_O, CORE_VALID_O SHALL be 0; OUT_DATA_O, CORE_DATA_O 8'h00.
REQ-032 Reset mid-block SHALL abandon partial input and output bursts; first post-reset block goes to core 0.

Verification
REQ-033 One block 00..0F, NUM_CORES=4, all ready -> CORE_VALID_O=4'b0001 for 16 cycles starting 1 cycle later, bytes 00..0F; wr_ptr=1.
REQ-034 Blocks A,B,C,D to cores 0..3; core 2 returns first, then 3,0,1 -> OUT emits results A,B,C,D order, 16 contiguous cycles each.
REQ-035 Fifth block while core 0 busy -> IN_READY_O=0 until core 0 result fully output, then block goes to core 0.
REQ-036 CORE_VALID_I[1] pulsed with busy[1]=0 -> ERR_O=1 and stays 1 until reset; OUT unaffected.
REQ-037 CE_I low 5 cycles mid-FEED and mid-SEND -> streams pause, resume with no lost or duplicated bytes.
REQ-038 RESET_I low at byte 8 of FEED -> all outputs 0 immediately; next block dispatched to core 0.

Source files
------------

// File: rtl/aes_core_dispatch.sv
// rtl/aes_core_dispatch.sv - round-robin dispatcher feeding NUM_CORES AES cores, reordering results to input order
module aes_core_dispatch #(
    parameter int NUM_CORES = 4
) (
    input  logic                   CLK_I,
    input  logic                   RESET_I,
    input  logic                   CE_I,
    input  logic [7:0]             IN_DATA_I,
    input  logic                   IN_VALID_I,
    output logic                   IN_READY_O,
    output logic [7:0]             OUT_DATA_O,
    output logic                   OUT_VALID_O,
    output logic [8*NUM_CORES-1:0] CORE_DATA_O,
    output logic [NUM_CORES-1:0]   CORE_VALID_O,
    input  logic [NUM_CORES-1:0]   CORE_READY_I,
    input  logic [8*NUM_CORES-1:0] CORE_DATA_I,
    input  logic [NUM_CORES-1:0]   CORE_VALID_I,
    output logic                   ERR_O
);

    localparam int PW = $clog2(NUM_CORES);

    localparam logic [0:0] IN_IDLE  = 1'b0;
    localparam logic [0:0] IN_FEED  = 1'b1;
    localparam logic [0:0] OUT_IDLE = 1'b0;
    localparam logic [0:0] OUT_SEND = 1'b1;

    logic [0:0]             r_in_state;
    logic [3:0]             r_in_cnt;
    logic [PW-1:0]          r_wr_ptr;
    logic                   r_alive;
    logic [8*NUM_CORES-1:0] r_core_data;
    logic [NUM_CORES-1:0]   r_core_valid;

    logic [0:0]             r_out_state;
    logic [3:0]             r_out_cnt;
    logic [PW-1:0]          r_rd_ptr;
    logic [7:0]             r_out_data;
    logic                   r_out_valid;

    logic [NUM_CORES-1:0]   r_busy;
    logic [NUM_CORES-1:0]   r_full;
    logic [3:0]             r_cap_cnt [NUM_CORES];
    logic [7:0]             r_buf     [NUM_CORES][16];
    logic                   r_err;

    logic                   w_accept;
    logic                   w_feed_byte;
    logic                   w_feed_done;
    logic                   w_fwd;
    logic                   w_release;
    logic [NUM_CORES-1:0]   w_wr_onehot;
    logic [NUM_CORES-1:0]   w_cap_ok;
    logic [NUM_CORES-1:0]   w_cap_bad;

    // r_alive keeps IN_READY_O low while reset is asserted even if cores report ready
    assign IN_READY_O  = r_alive & CORE_READY_I[r_wr_ptr] & ~r_busy[r_wr_ptr]
                       & (r_in_state == IN_IDLE);
    assign w_accept    = CE_I & IN_VALID_I & IN_READY_O;
    assign w_feed_byte = CE_I & IN_VALID_I & (r_in_state == IN_FEED);
    assign w_feed_done = w_feed_byte & (r_in_cnt == 4'd15);
    assign w_fwd       = w_accept | w_feed_byte;
    assign w_release   = CE_I & (r_out_state == OUT_SEND) & (r_out_cnt == 4'd15);
    assign w_wr_onehot = {{(NUM_CORES-1){1'b0}}, 1'b1} << r_wr_ptr;

    genvar g;
    generate
        for (g = 0; g < NUM_CORES; g++) begin : g_cap
            assign w_cap_ok[g]  = CE_I & CORE_VALID_I[g] & r_busy[g] & ~r_full[g];
            assign w_cap_bad[g] = CE_I & CORE_VALID_I[g] & ~(r_busy[g] & ~r_full[g]);
        end
    endgenerate

    always_ff @(posedge CLK_I or negedge RESET_I) begin
        if (!RESET_I) begin
            r_in_state   <= IN_IDLE;
            r_in_cnt     <= 4'd0;
            r_wr_ptr     <= '0;
            r_alive      <= 1'b0;
            r_core_data  <= '0;
            r_core_valid <= '0;
        end else if (CE_I) begin
            r_alive      <= 1'b1;
            r_core_valid <= w_fwd ? w_wr_onehot : '0;
            for (int k = 0; k < NUM_CORES; k++) begin
                if (w_fwd && (r_wr_ptr == PW'(k))) begin
                    r_core_data[8*k +: 8] <= IN_DATA_I;
                end
            end
            case (r_in_state)
                IN_IDLE: begin
                    if (w_accept) begin
                        r_in_state <= IN_FEED;
                        r_in_cnt   <= 4'd1;
                    end
                end
                default: begin
                    if (w_feed_byte) begin
                        r_in_cnt <= r_in_cnt + 4'd1;
                    end
                    if (w_feed_done) begin
                        r_in_state <= IN_IDLE;
                        r_wr_ptr   <= r_wr_ptr + PW'(1);
                    end
                end
            endcase
        end
    end

    // accept requires ~busy, so a release and a dispatch never hit the same core in one cycle
    always_ff @(posedge CLK_I or negedge RESET_I) begin
        if (!RESET_I) begin
            r_busy <= '0;
            r_full <= '0;
            r_err  <= 1'b0;
            for (int k = 0; k < NUM_CORES; k++) begin
                r_cap_cnt[k] <= 4'd0;
            end
        end else if (CE_I) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (w_cap_ok[k]) begin
                    r_cap_cnt[k] <= r_cap_cnt[k] + 4'd1;
                    if (r_cap_cnt[k] == 4'd15) begin
                        r_full[k] <= 1'b1;
                    end
                end
                if (w_cap_bad[k]) begin
                    r_err <= 1'b1;
                end
                if (w_release && (r_rd_ptr == PW'(k))) begin
                    r_busy[k] <= 1'b0;
                    r_full[k] <= 1'b0;
                end
                if (w_accept && (r_wr_ptr == PW'(k))) begin
                    r_busy[k] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        for (int k = 0; k < NUM_CORES; k++) begin
            if (w_cap_ok[k]) begin
                r_buf[k][r_cap_cnt[k]] <= CORE_DATA_I[8*k +: 8];
            end
        end
    end

    // byte 16 and the release share an edge, so a waiting full buffer follows with no gap
    always_ff @(posedge CLK_I or negedge RESET_I) begin
        if (!RESET_I) begin
            r_out_state <= OUT_IDLE;
            r_out_cnt   <= 4'd0;
            r_rd_ptr    <= '0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
        end else if (CE_I) begin
            case (r_out_state)
                OUT_IDLE: begin
                    if (r_full[r_rd_ptr]) begin
                        r_out_state <= OUT_SEND;
                        r_out_data  <= r_buf[r_rd_ptr][r_out_cnt];
                        r_out_valid <= 1'b1;
                        r_out_cnt   <= r_out_cnt + 4'd1;
                    end else begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_data  <= r_buf[r_rd_ptr][r_out_cnt];
                    r_out_valid <= 1'b1;
                    r_out_cnt   <= r_out_cnt + 4'd1;
                    if (r_out_cnt == 4'd15) begin
                        r_out_state <= OUT_IDLE;
                        r_rd_ptr    <= r_rd_ptr + PW'(1);
                    end
                end
            endcase
        end
    end

    assign CORE_DATA_O  = r_core_data;
    assign CORE_VALID_O = r_core_valid;
    assign OUT_DATA_O   = r_out_data;
    assign OUT_VALID_O  = r_out_valid;
    assign ERR_O        = r_err;

endmodule
